// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: sequential load/store unit between the MEM stage and data memory.
// Accepts one request per valid/ready handshake and performs it on a chip-select /
// grant / rvalid memory port with byte enables. It stalls the pipeline, by keeping
// ready low, until the one-cycle done pulse.
// Load data is returned sign- or zero-extended. XLEN may be 32 or 64.
// Build option: define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into
// two beats. Without it, a word-crossing access completes at once with
// misalign_exc_o set and no memory traffic.
// Misalignment inside a single bus word is always served in one beat.
module lsu_mem_ctrl #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lsu_valid_i,
    output logic                lsu_ready_o,
    input  logic                lsu_store_i,
    input  logic [2:0]          funct3_i,
    input  logic [XLEN-1:0]     addr_i,
    input  logic [XLEN-1:0]     wdata_i,
    output logic                lsu_done_o,
    output logic [XLEN-1:0]     rdata_o,
    output logic                misalign_exc_o,
    output logic                mem_cs_o,
    output logic                mem_wr_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN/8-1:0]   mem_mask_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [XLEN-1:0]     mem_rdata_i
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT0 = 3'd1,
        S_WAIT0 = 3'd2,
        S_BEAT1 = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    // Registered state and request context
    state_t                 state_q;
    logic                   store_q;
    logic [2:0]             funct3_q;
    logic [OFFW-1:0]        off_q;
    logic                   cross_q;
    logic [NB-1:0]          mask_hi_q;
    logic [XLEN-1:0]        wdata_hi_q;
    logic [2*XLEN-1:0]      buf_q;

    // Registered outputs
    logic                   ready_q;
    logic                   done_q;
    logic                   exc_q;
    logic [XLEN-1:0]        rdata_q;
    logic                   cs_q;
    logic                   wr_q;
    logic [XLEN-1:0]        addr_q;
    logic [NB-1:0]          mask_q;
    logic [XLEN-1:0]        wdata_q;

    // Request decode (combinational, used on accept)
    logic [OFFW-1:0]        req_off_s;
    logic [4:0]             req_size_s;
    logic [4:0]             req_end_s;
    logic                   req_cross_s;
    logic                   req_illegal_s;
    logic [XLEN-1:0]        req_base_s;
    logic [2*NB-1:0]        req_en_s;
    logic [2*XLEN-1:0]      req_wsel_s;
    logic [2*NB-1:0]        req_mask_s;
    logic [2*XLEN-1:0]      req_wdata_s;

    // Load path
    logic [2*XLEN-1:0]      buf_next_s;
    logic [XLEN-1:0]        load_raw_s;
    logic [XLEN-1:0]        load_data_s;
    logic [XLEN-1:0]        beat1_addr_s;

    // Extend the low 8<<f3[1:0] bits of raw; f3[2] selects zero extension.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                    input logic [2:0]      f3);
        int               nbits;
        logic             sign;
        logic [XLEN-1:0]  res;
        nbits = 8 << f3[1:0];
        if (nbits > XLEN) begin
            nbits = XLEN;
        end else begin
            nbits = nbits;
        end
        sign = raw[nbits-1] & ~f3[2];
        for (int i = 0; i < XLEN; i++) begin
            if (i < nbits) begin
                res[i] = raw[i];
            end else begin
                res[i] = sign;
            end
        end
        return res;
    endfunction

    assign lsu_ready_o    = ready_q;
    assign lsu_done_o     = done_q;
    assign misalign_exc_o = exc_q;
    assign rdata_o        = rdata_q;
    assign mem_cs_o       = cs_q;
    assign mem_wr_o       = wr_q;
    assign mem_addr_o     = addr_q;
    assign mem_mask_o     = mask_q;
    assign mem_wdata_o    = wdata_q;

    // Decode the incoming request: size, offset, word crossing, legality, lanes
    always_comb begin
        req_off_s  = addr_i[OFFW-1:0];
        req_size_s = 5'd1 << funct3_i[1:0];
        req_end_s  = 5'(req_off_s) + req_size_s;
        req_cross_s = (req_end_s > 5'(NB));
        if (XLEN == 64) begin
            req_illegal_s = (funct3_i == 3'b111);
        end else begin
            req_illegal_s = (funct3_i[1:0] == 2'b11) || (funct3_i == 3'b110);
        end
        req_base_s = addr_i;
        req_base_s[OFFW-1:0] = {OFFW{1'b0}};
        req_en_s   = {(2*NB){1'b0}};
        req_wsel_s = {(2*XLEN){1'b0}};
        for (int i = 0; i < NB; i++) begin
            if (i < int'(req_size_s)) begin
                req_en_s[i]         = 1'b1;
                req_wsel_s[8*i +: 8] = wdata_i[8*i +: 8];
            end else begin
                req_en_s[i]         = 1'b0;
                req_wsel_s[8*i +: 8] = 8'h00;
            end
        end
        // Lanes beyond NB spill into the second beat
        req_mask_s  = req_en_s << req_off_s;
        req_wdata_s = req_wsel_s << {req_off_s, 3'b000};
    end

    // Merge returning read data into the two-word assembly buffer and extend it
    always_comb begin
        buf_next_s = buf_q;
        case (state_q)
            S_WAIT0: buf_next_s[XLEN-1:0]      = mem_rdata_i;
            S_WAIT1: buf_next_s[2*XLEN-1:XLEN] = mem_rdata_i;
            default: buf_next_s = buf_q;
        endcase
        load_raw_s   = XLEN'(buf_next_s >> {off_q, 3'b000});
        load_data_s  = extend_load(load_raw_s, funct3_q);
        // Second beat is the next bus word; wraps at the top of the address space
        beat1_addr_s = addr_q + XLEN'(NB);
    end

    // Access sequencer with registered memory-port and pipeline outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            store_q    <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= {OFFW{1'b0}};
            cross_q    <= 1'b0;
            mask_hi_q  <= {NB{1'b0}};
            wdata_hi_q <= {XLEN{1'b0}};
            buf_q      <= {(2*XLEN){1'b0}};
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            exc_q      <= 1'b0;
            rdata_q    <= {XLEN{1'b0}};
            cs_q       <= 1'b1;
            wr_q       <= 1'b1;
            addr_q     <= {XLEN{1'b0}};
            mask_q     <= {NB{1'b0}};
            wdata_q    <= {XLEN{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    exc_q  <= 1'b0;
                    if (lsu_valid_i && ready_q) begin
                        ready_q    <= 1'b0;
                        store_q    <= lsu_store_i;
                        funct3_q   <= funct3_i;
                        off_q      <= req_off_s;
                        cross_q    <= req_cross_s;
                        mask_hi_q  <= req_mask_s[2*NB-1:NB];
                        wdata_hi_q <= req_wdata_s[2*XLEN-1:XLEN];
                        buf_q      <= {(2*XLEN){1'b0}};
                        if (req_illegal_s) begin
                            // Unsupported size: complete quietly with zero data
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                            rdata_q <= {XLEN{1'b0}};
                        end else if (req_cross_s && !SPLIT_EN) begin
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                            exc_q   <= 1'b1;
                            rdata_q <= {XLEN{1'b0}};
                        end else begin
                            state_q <= S_BEAT0;
                            cs_q    <= 1'b0;
                            wr_q    <= ~lsu_store_i;
                            addr_q  <= req_base_s;
                            mask_q  <= req_mask_s[NB-1:0];
                            wdata_q <= req_wdata_s[XLEN-1:0];
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_BEAT0: begin
                    if (mem_gnt_i) begin
                        if (store_q && cross_q) begin
                            state_q <= S_BEAT1;
                            cs_q    <= 1'b0;
                            addr_q  <= beat1_addr_s;
                            mask_q  <= mask_hi_q;
                            wdata_q <= wdata_hi_q;
                        end else if (store_q) begin
                            state_q <= S_RESP;
                            cs_q    <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_WAIT0;
                            cs_q    <= 1'b1;
                        end
                    end else begin
                        state_q <= S_BEAT0;
                    end
                end
                S_WAIT0: begin
                    if (mem_rvalid_i) begin
                        buf_q <= buf_next_s;
                        if (cross_q) begin
                            state_q <= S_BEAT1;
                            cs_q    <= 1'b0;
                            addr_q  <= beat1_addr_s;
                            mask_q  <= mask_hi_q;
                        end else begin
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                            rdata_q <= load_data_s;
                        end
                    end else begin
                        state_q <= S_WAIT0;
                    end
                end
                S_BEAT1: begin
                    if (mem_gnt_i) begin
                        cs_q <= 1'b1;
                        if (store_q) begin
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_WAIT1;
                        end
                    end else begin
                        state_q <= S_BEAT1;
                    end
                end
                S_WAIT1: begin
                    if (mem_rvalid_i) begin
                        buf_q   <= buf_next_s;
                        state_q <= S_RESP;
                        done_q  <= 1'b1;
                        rdata_q <= load_data_s;
                    end else begin
                        state_q <= S_WAIT1;
                    end
                end
                S_RESP: begin
                    done_q  <= 1'b0;
                    exc_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    exc_q   <= 1'b0;
                    ready_q <= 1'b1;
                    cs_q    <= 1'b1;
                    wr_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl (XLEN=32) with a small memory responder.
// The responder has a programmable grant delay and read latency. Expected values
// are hand-computed. Word-crossing cases follow LSU_MISALIGN_SPLIT_EN.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic        lsu_store_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        lsu_done_o;
    logic [31:0] rdata_o;
    logic        misalign_exc_o;
    logic        mem_cs_o;
    logic        mem_wr_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_mask_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    int checks = 0;
    int failures = 0;

    // responder controls
    int gnt_delay = 0;
    int rv_delay  = 1;
    int wait_cnt  = 0;
    int rv_cnt    = 0;
    logic rv_pend = 1'b0;
    logic [31:0] rv_addr = 32'h0;
    logic [31:0] mem [logic [31:0]];

    // beat log
    logic [31:0] beat_addr [$];
    logic [31:0] beat_mask [$];
    logic [31:0] beat_wdata [$];
    logic [31:0] beat_wr [$];
    int cs_low_cnt = 0;

    lsu_mem_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_store_i(lsu_store_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .lsu_done_o(lsu_done_o), .rdata_o(rdata_o), .misalign_exc_o(misalign_exc_o),
        .mem_cs_o(mem_cs_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_mask_o(mem_mask_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    assign mem_gnt_i = !mem_cs_o && (wait_cnt >= gnt_delay);

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        else return 32'h0;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int idx);
        if (idx < q.size()) return q[idx];
        else return 32'hBAD0BAD0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // memory responder: grant after gnt_delay cycles, read data rv_delay cycles after grant
    always @(posedge clk) begin
        logic [31:0] w;
        mem_rvalid_i <= 1'b0;
        if (rv_pend) begin
            if (rv_cnt == 1) begin
                mem_rvalid_i <= 1'b1;
                mem_rdata_i  <= mem_rd(rv_addr);
                rv_pend      <= 1'b0;
            end else begin
                rv_cnt <= rv_cnt - 1;
            end
        end
        if (!mem_cs_o) begin
            if (mem_gnt_i) begin
                wait_cnt <= 0;
                beat_addr.push_back(mem_addr_o);
                beat_mask.push_back({28'h0, mem_mask_o});
                beat_wdata.push_back(mem_wdata_o);
                beat_wr.push_back({31'h0, mem_wr_o});
                if (mem_wr_o) begin
                    if (rv_delay == 1) begin
                        mem_rvalid_i <= 1'b1;
                        mem_rdata_i  <= mem_rd(mem_addr_o);
                    end else begin
                        rv_pend <= 1'b1;
                        rv_cnt  <= rv_delay - 1;
                        rv_addr <= mem_addr_o;
                    end
                end else begin
                    w = mem_rd(mem_addr_o);
                    for (int b = 0; b < 4; b++)
                        if (mem_mask_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
                    mem[mem_addr_o] = w;
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    // count cycles with chip select asserted
    always @(negedge clk) if (!mem_cs_o) cs_low_cnt++;

    // issue one request and wait for done; lat = clock edges after the accept edge
    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output int lat);
        logic seen;
        @(negedge clk);
        lsu_valid_i = 1'b1; lsu_store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
        @(posedge clk);
        #1;
        lsu_valid_i = 1'b0;
        cs_low_cnt = 0;
        beat_addr.delete(); beat_mask.delete(); beat_wdata.delete(); beat_wr.delete();
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lsu_done_o) begin seen = 1'b1; break; end
            @(posedge clk);
            lat++;
        end
        check("done_seen", {63'h0, seen}, 64'd1);
    endtask

    initial begin
        int lat;
        logic saw_done;
        mem[32'h100] = 32'hDEADBEEF;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_ready", lsu_ready_o, 1);
        check("rst_cs", mem_cs_o, 1);
        check("rst_wr", mem_wr_o, 1);
        check("rst_done", lsu_done_o, 0);
        check("rst_exc", misalign_exc_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_mask", mem_mask_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        rst_n = 1'b1;

        // 1: LW 0x100, grant immediately, rvalid next cycle
        gnt_delay = 0; rv_delay = 1;
        run_req(1'b0, 3'b010, 32'h100, 32'h0, lat);
        check("t1_lat", lat, 2);
        check("t1_rdata", rdata_o, 32'hDEADBEEF);
        check("t1_exc", misalign_exc_o, 0);
        check("t1_ready_busy", lsu_ready_o, 0);
        check("t1_nbeats", beat_addr.size(), 1);
        check("t1_addr", q_at(beat_addr, 0), 32'h100);
        check("t1_mask", q_at(beat_mask, 0), 32'hF);
        check("t1_wr", q_at(beat_wr, 0), 1);
        @(negedge clk);
        check("t1_done_pulse", lsu_done_o, 0);
        check("t1_ready_back", lsu_ready_o, 1);

        // 2: byte/half loads with sign and zero extension
        mem[32'h100] = 32'h80123456;
        run_req(1'b0, 3'b000, 32'h103, 32'h0, lat);
        check("t2_lb", rdata_o, 32'hFFFFFF80);
        check("t2_lb_mask", q_at(beat_mask, 0), 32'h8);
        run_req(1'b0, 3'b100, 32'h103, 32'h0, lat);
        check("t2_lbu", rdata_o, 32'h00000080);
        run_req(1'b0, 3'b001, 32'h102, 32'h0, lat);
        check("t2_lh", rdata_o, 32'hFFFF8012);
        check("t2_lh_mask", q_at(beat_mask, 0), 32'hC);
        run_req(1'b0, 3'b101, 32'h101, 32'h0, lat);
        check("t2_lhu_inword", rdata_o, 32'h00001234);
        check("t2_lhu_mask", q_at(beat_mask, 0), 32'h6);

        // 3: SH 0x202 with grant delayed 3 cycles; rdata_o holds last load value
        gnt_delay = 3;
        run_req(1'b1, 3'b001, 32'h202, 32'hABCD1234, lat);
        check("t3_lat", lat, 4);
        check("t3_cs_low", cs_low_cnt, 4);
        check("t3_addr", q_at(beat_addr, 0), 32'h200);
        check("t3_mask", q_at(beat_mask, 0), 32'hC);
        check("t3_wdata", q_at(beat_wdata, 0), 32'h12340000);
        check("t3_wr", q_at(beat_wr, 0), 0);
        check("t3_rdata_held", rdata_o, 32'h00001234);
        check("t3_mem", mem_rd(32'h200), 32'h12340000);
        gnt_delay = 0;

        // 4/5: word-crossing accesses
        mem[32'h100] = 32'h11AABBCC;
        mem[32'h104] = 32'h55443322;
`ifdef LSU_MISALIGN_SPLIT_EN
        run_req(1'b0, 3'b010, 32'h103, 32'h0, lat);
        check("t4_lat", lat, 4);
        check("t4_nbeats", beat_addr.size(), 2);
        check("t4_addr0", q_at(beat_addr, 0), 32'h100);
        check("t4_mask0", q_at(beat_mask, 0), 32'h8);
        check("t4_addr1", q_at(beat_addr, 1), 32'h104);
        check("t4_mask1", q_at(beat_mask, 1), 32'h7);
        check("t4_rdata", rdata_o, 32'h44332211);
        check("t4_exc", misalign_exc_o, 0);
        run_req(1'b1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D, lat);
        check("t5_lat", lat, 2);
        check("t5_nbeats", beat_addr.size(), 2);
        check("t5_addr0", q_at(beat_addr, 0), 32'hFFFFFFFC);
        check("t5_mask0", q_at(beat_mask, 0), 32'hC);
        check("t5_wdata0", q_at(beat_wdata, 0), 32'hF00D0000);
        check("t5_addr1", q_at(beat_addr, 1), 32'h0);
        check("t5_mask1", q_at(beat_mask, 1), 32'h3);
        check("t5_wdata1", q_at(beat_wdata, 1), 32'h0000CAFE);
        check("t5_exc", misalign_exc_o, 0);
`else
        run_req(1'b0, 3'b010, 32'h103, 32'h0, lat);
        check("t4_lat", lat, 0);
        check("t4_nbeats", beat_addr.size(), 0);
        check("t4_exc", misalign_exc_o, 1);
        check("t4_rdata", rdata_o, 32'h0);
        run_req(1'b1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D, lat);
        check("t5_lat", lat, 0);
        check("t5_cs_low", cs_low_cnt, 0);
        check("t5_exc", misalign_exc_o, 1);
        @(negedge clk);
        check("t5_exc_pulse", misalign_exc_o, 0);
`endif

        // illegal funct3 (LD on XLEN=32): done, zero data, no access, no exception
        mem[32'h100] = 32'h7F00007F;
        run_req(1'b0, 3'b000, 32'h100, 32'h0, lat);
        check("ill_pre", rdata_o, 32'h0000007F);
        run_req(1'b0, 3'b011, 32'h100, 32'h0, lat);
        check("ill_lat", lat, 0);
        check("ill_rdata", rdata_o, 32'h0);
        check("ill_exc", misalign_exc_o, 0);
        check("ill_nbeats", beat_addr.size(), 0);

        // 6: async reset while waiting for read data; late rvalid must be ignored
        rv_delay = 3;
        @(negedge clk);
        lsu_valid_i = 1'b1; lsu_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h100;
        @(posedge clk);
        #1 lsu_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_in_wait", mem_cs_o, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", lsu_ready_o, 1);
        check("t6_rst_cs", mem_cs_o, 1);
        check("t6_rst_addr", mem_addr_o, 0);
        check("t6_rst_mask", mem_mask_o, 0);
        check("t6_rst_rdata", rdata_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (lsu_done_o) saw_done = 1'b1;
        end
        check("t6_no_done", saw_done, 0);
        check("t6_ready", lsu_ready_o, 1);
        check("t6_cs", mem_cs_o, 1);
        rv_delay = 1;
        run_req(1'b0, 3'b010, 32'h100, 32'h0, lat);
        check("t6_recover", rdata_o, 32'h7F00007F);
        check("t6_recover_lat", lat, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
